gpio_in_filter: RTL and testbench

- Per-pin input conditioning stage between the GPIO pads and the `gpio_in` port of the APB GPIO peripheral.
- Resynchronises each pad input with a 2-flop synchroniser.
- Applies a programmable, prescaled glitch/debounce filter per pin.
- Presents clean, registered levels on `gpio_filt`, so edge/level interrupts downstream never see bounce.

---
 rtl/gpio_in_filter.sv | 88 ++++++++
 tb/tb_gpio_in_filter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_in_filter.sv
// GPIO input conditioning: 2-flop synchroniser followed by a per-pin, prescaled debounce filter.
// Define GPIO_FILT_EDGE_EN to add registered single-cycle edge_rise/edge_fall pulses.
module gpio_in_filter #(
    parameter int NPINS       = 32,
    parameter int FILT_WIDTH  = 4,
    parameter int PRESC_WIDTH = 8
) (
    input  logic                   HCLK,
    input  logic                   HRESET,
    input  logic [NPINS-1:0]       pad_in,
    input  logic [NPINS-1:0]       cfg_en,
    input  logic [PRESC_WIDTH-1:0] cfg_presc,
    input  logic [FILT_WIDTH-1:0]  cfg_thresh,
`ifdef GPIO_FILT_EDGE_EN
    output logic [NPINS-1:0]       edge_rise,
    output logic [NPINS-1:0]       edge_fall,
`endif
    output logic [NPINS-1:0]       gpio_filt
);

    logic [NPINS-1:0]       s0;
    logic [NPINS-1:0]       s1;
    logic [NPINS-1:0]       filt_nxt;
    logic [PRESC_WIDTH-1:0] pc;
    logic                   tick;
    logic [FILT_WIDTH-1:0]  cnt     [NPINS];
    logic [FILT_WIDTH-1:0]  cnt_nxt [NPINS];

    // Using >= rather than == means lowering cfg_presc below pc ticks at once instead of wrapping.
    assign tick = (pc >= cfg_presc);

    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path can infer a latch.
        filt_nxt = gpio_filt;
        for (int i = 0; i < NPINS; i++) begin
            cnt_nxt[i] = cnt[i];
            if (!cfg_en[i]) begin
                filt_nxt[i] = s1[i];
                cnt_nxt[i]  = '0;
            end else if (s1[i] == gpio_filt[i]) begin
                cnt_nxt[i]  = '0;
            end else if (tick) begin
                if (cnt[i] >= cfg_thresh) begin
                    filt_nxt[i] = s1[i];
                    cnt_nxt[i]  = '0;
                end else begin
                    cnt_nxt[i]  = cnt[i] + 1'b1;
                end
            end
        end
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            s0        <= '0;
            s1        <= '0;
            gpio_filt <= '0;
            pc        <= '0;
            // NOTE: the counter array is control state, not data storage, so it must be reset.
            for (int i = 0; i < NPINS; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            s0        <= pad_in;
            s1        <= s0;
            gpio_filt <= filt_nxt;
            pc        <= tick ? '0 : pc + 1'b1;
            for (int i = 0; i < NPINS; i++) begin
                cnt[i] <= cnt_nxt[i];
            end
        end
    end

`ifdef GPIO_FILT_EDGE_EN
    // Pulses are produced on the same edge that changes gpio_filt.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            edge_rise <= '0;
            edge_fall <= '0;
        end else begin
            edge_rise <= filt_nxt & ~gpio_filt;
            edge_fall <= ~filt_nxt & gpio_filt;
        end
    end
`endif

endmodule

// File: tb/tb_gpio_in_filter.sv
// Self-checking bench for gpio_in_filter: latency vector table, corner sequences and a randomized model run.
module tb_gpio_in_filter;

    localparam int N  = 32;
    localparam int FW = 4;
    localparam int PW = 8;

    logic          HCLK = 1'b0;
    logic          HRESET = 1'b1;
    logic [N-1:0]  pad_in = '0;
    logic [N-1:0]  cfg_en = '0;
    logic [PW-1:0] cfg_presc = '0;
    logic [FW-1:0] cfg_thresh = '0;
    logic [N-1:0]  gpio_filt;
`ifdef GPIO_FILT_EDGE_EN
    logic [N-1:0]  edge_rise;
    logic [N-1:0]  edge_fall;
`endif

    gpio_in_filter #(.NPINS(N), .FILT_WIDTH(FW), .PRESC_WIDTH(PW)) dut (
        .HCLK       (HCLK),
        .HRESET     (HRESET),
        .pad_in     (pad_in),
        .cfg_en     (cfg_en),
        .cfg_presc  (cfg_presc),
        .cfg_thresh (cfg_thresh),
`ifdef GPIO_FILT_EDGE_EN
        .edge_rise  (edge_rise),
        .edge_fall  (edge_fall),
`endif
        .gpio_filt  (gpio_filt)
    );

    always #5 HCLK = ~HCLK;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reset with the given configuration; returns #1 after "edge 0", the first edge after release.
    task automatic start_test(input logic [N-1:0] en, input int presc, input int thresh);
        @(negedge HCLK);
        HRESET     = 1'b1;
        pad_in     = '0;
        cfg_en     = en;
        cfg_presc  = PW'(presc);
        cfg_thresh = FW'(thresh);
        @(negedge HCLK);
        HRESET = 1'b0;
        @(posedge HCLK);
        #1;
    endtask

    // Counts rising edges until gpio_filt[pin] is 1; -1 if the bound expires.
    task automatic measure_rise(input int pin, input int limit, output int lat);
        lat = -1;
        for (int k = 1; k <= limit; k++) begin
            @(posedge HCLK);
            #1;
            if (gpio_filt[pin]) begin
                lat = k;
                break;
            end
        end
    endtask

    // Reference model: level seen two edges late, ticks every presc+1 cycles,
    // a new level is accepted on the (thresh+1)-th tick of an unbroken mismatch.
    logic [N-1:0] m_filt, m_d1, m_d2, m_rise, m_fall;
    int           m_streak [N];
    int           m_since;

    task automatic model_reset();
        m_filt = '0; m_d1 = '0; m_d2 = '0; m_rise = '0; m_fall = '0;
        m_since = 0;
        for (int i = 0; i < N; i++) m_streak[i] = 0;
    endtask

    task automatic model_step();
        logic [N-1:0] old_filt;
        logic         t;
        old_filt = m_filt;
        t = (m_since >= int'(cfg_presc));
        for (int i = 0; i < N; i++) begin
            if (!cfg_en[i]) begin
                m_filt[i] = m_d2[i];
                m_streak[i] = 0;
            end else if (m_d2[i] == m_filt[i]) begin
                m_streak[i] = 0;
            end else if (t) begin
                if (m_streak[i] >= int'(cfg_thresh)) begin
                    m_filt[i] = m_d2[i];
                    m_streak[i] = 0;
                end else begin
                    m_streak[i] = m_streak[i] + 1;
                end
            end
        end
        m_since = t ? 0 : m_since + 1;
        m_d2 = m_d1;
        m_d1 = pad_in;
        m_rise = m_filt & ~old_filt;
        m_fall = ~m_filt & old_filt;
    endtask

    typedef struct {
        logic en;
        int   presc;
        int   thresh;
        int   pin;
        int   lat;
    } vec_t;

    vec_t vecs [8];

    initial begin
        int           lat;
        logic [N-1:0] mask;
        logic         bad;

        vecs[0] = '{1'b0, 0, 0,  0,  3};
        vecs[1] = '{1'b1, 0, 5,  3,  8};
        vecs[2] = '{1'b1, 0, 0,  5,  3};
        vecs[3] = '{1'b1, 0, 15, 31, 18};
        vecs[4] = '{1'b1, 3, 2,  3,  11};
        vecs[5] = '{1'b1, 1, 1,  1,  5};
        vecs[6] = '{1'b1, 7, 0,  9,  7};
        vecs[7] = '{1'b0, 7, 9,  31, 3};

        @(negedge HCLK);
        #1;
        check("reset_state", gpio_filt, '0);

        for (int v = 0; v < 8; v++) begin
            start_test(vecs[v].en ? '1 : '0, vecs[v].presc, vecs[v].thresh);
            pad_in[vecs[v].pin] = 1'b1;
            measure_rise(vecs[v].pin, 40, lat);
            check($sformatf("vec%0d_latency", v), N'(lat), N'(vecs[v].lat));
            mask = '0;
            mask[vecs[v].pin] = 1'b1;
            check($sformatf("vec%0d_other_pins", v), gpio_filt & ~mask, '0);
        end

        // Glitch of 4 cycles is rejected, and the count restarts for the following steady high.
        start_test(32'h8, 0, 5);
        pad_in[3] = 1'b1;
        repeat (4) begin
            @(posedge HCLK);
            #1;
        end
        pad_in[3] = 1'b0;
        bad = 1'b0;
        repeat (20) begin
            @(posedge HCLK);
            #1;
            bad = bad | gpio_filt[3];
        end
        check("glitch_reject", N'(bad), '0);
        pad_in[3] = 1'b1;
        measure_rise(3, 40, lat);
        check("glitch_then_steady_latency", N'(lat), N'(8));

        // Asynchronous reset in the middle of a count.
        start_test(32'h8, 0, 5);
        pad_in[3] = 1'b1;
        pad_in[0] = 1'b1;
        repeat (5) @(posedge HCLK);
        #2;
        check("pre_reset_bypass_pin0", N'(gpio_filt[0]), N'(1));
        HRESET = 1'b1;
        #1;
        check("reset_async_clear", gpio_filt, '0);
        #1;
        HRESET = 1'b0;
        measure_rise(3, 40, lat);
        check("post_reset_latency", N'(lat), N'(8));

`ifdef GPIO_FILT_EDGE_EN
        start_test('0, 0, 0);
        mask = '0;
        mask[7] = 1'b1;
        pad_in[7] = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(posedge HCLK);
            #1;
            check($sformatf("edge_rise_k%0d", k), edge_rise, (k == 3) ? mask : '0);
            check($sformatf("edge_fall_quiet_k%0d", k), edge_fall, '0);
        end
        pad_in[7] = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(posedge HCLK);
            #1;
            check($sformatf("edge_fall_k%0d", k), edge_fall, (k == 3) ? mask : '0);
            check($sformatf("edge_rise_quiet_k%0d", k), edge_rise, '0);
        end
`endif

        // Randomized run against the model, with reconfiguration every 250 cycles.
        @(negedge HCLK);
        HRESET = 1'b1;
        pad_in = '0;
        model_reset();
        @(negedge HCLK);
        HRESET = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc % 250 == 0) begin
                cfg_en     = $urandom;
                cfg_presc  = PW'($urandom_range(0, 5));
                cfg_thresh = FW'($urandom_range(0, 15));
            end
            if (cyc % 500 < 250)
                pad_in = pad_in ^ ($urandom & $urandom & $urandom & $urandom);
            else
                pad_in = pad_in ^ ($urandom & $urandom & $urandom & $urandom & $urandom & $urandom);
            model_step();
            @(posedge HCLK);
            #1;
            check("rand_gpio_filt", gpio_filt, m_filt);
`ifdef GPIO_FILT_EDGE_EN
            check("rand_edge_rise", edge_rise, m_rise);
            check("rand_edge_fall", edge_fall, m_fall);
`endif
            @(negedge HCLK);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
